engine_scheduler: RTL and testbench

//  Master end of the engine bus. Scans the screen in raster order and dispatches one pixel
//  per available engine (engine_addr/in_word/latch_en). Round-robin services engines raising

---
 rtl/engine_scheduler.sv | 237 +++++++++++++++++++++++
 tb/tb_engine_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_scheduler.sv
// engine_scheduler: master end of the engine bus.
//   Dispatch side walks the screen in raster order and hands one pixel to the
//   lowest-index available engine (engine_addr / in_word / latch_en).
//   Collect side round-robin acknowledges engines raising service_req, captures
//   the shared out_word bus and writes the iteration count to the frame buffer.
// Ports:
//   Engine_CLK, eRST_n            clock, asynchronous active-low reset
//   start, re_start, im_start,    frame start pulse and view (signed Q8.24)
//   step
//   available, service_req        per-engine idle / result-ready flags
//   out_word                      shared result bus {x[9:0], y[8:0], iter[7:0]}
//   engine_addr, in_word,         dispatch target, {x, y, re, im}, strobe
//   latch_en
//   req_ack                       one-hot service acknowledge
//   fb_we, fb_addr, fb_data       frame-buffer write port
//   busy, frame_done              frame in progress / last result written
module engine_scheduler #(
  parameter int unsigned N_ENGINES = 8,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480
) (
  input  logic                 Engine_CLK,
  input  logic                 eRST_n,
  input  logic                 start,
  input  logic [31:0]          re_start,
  input  logic [31:0]          im_start,
  input  logic [31:0]          step,
  input  logic [N_ENGINES-1:0] available,
  input  logic [N_ENGINES-1:0] service_req,
  input  logic [26:0]          out_word,
  output logic [ADDR_W-1:0]    engine_addr,
  output logic [82:0]          in_word,
  output logic                 latch_en,
  output logic [N_ENGINES-1:0] req_ack,
  output logic                 fb_we,
  output logic [18:0]          fb_addr,
  output logic [7:0]           fb_data,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned IDX_W    = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [9:0]  X_LAST   = 10'(H_RES - 1);
  localparam logic [8:0]  Y_LAST   = 9'(V_RES - 1);
  localparam logic [18:0] PIX_LAST = 19'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {D_IDLE, D_SEL, D_PULSE, D_GAP} d_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ACK, C_HOLD} c_state_t;

  d_state_t d_state, d_next;
  c_state_t c_state, c_next;

  logic [31:0]          re_start_r;
  logic [31:0]          step_r;
  logic [9:0]           x_cnt;
  logic [8:0]           y_cnt;
  logic [31:0]          re_acc;
  logic [31:0]          im_acc;
  logic [ADDR_W-1:0]    addr_r;

  logic                 start_ok;
  logic                 last_pix;
  logic                 avail_any;
  logic [IDX_W-1:0]     avail_idx;

  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     ack_idx;
  logic [1:0]           mask_cnt;
  logic [N_ENGINES-1:0] mask_vec;
  logic [N_ENGINES-1:0] req_avail;
  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic [18:0]          cap_addr;
  logic [7:0]           cap_iter;
  logic [18:0]          res_cnt;

  assign start_ok    = start & ~busy;
  assign last_pix    = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign engine_addr = addr_r;
  assign in_word     = {x_cnt, y_cnt, re_acc, im_acc};

  // Lowest-index available engine: scan downwards so the last hit wins.
  always_comb begin
    avail_any = 1'b0;
    avail_idx = '0;
    for (int unsigned i = N_ENGINES; i > 0; i--) begin
      if (available[IDX_W'(i - 1)]) begin
        avail_any = 1'b1;
        avail_idx = IDX_W'(i - 1);
      end
    end
  end

  // ---------------- dispatch FSM ----------------
  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) d_state <= D_IDLE;
    else         d_state <= d_next;
  end

  always_comb begin
    d_next   = d_state;
    latch_en = 1'b0;
    case (d_state)
      D_IDLE:  if (start_ok) d_next = D_SEL;
      D_SEL:   if (avail_any) d_next = D_PULSE;
      D_PULSE: begin
        latch_en = 1'b1;
        d_next   = last_pix ? D_IDLE : D_GAP;
      end
      D_GAP:   d_next = D_SEL;
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) begin
      re_start_r <= '0;
      step_r     <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      re_acc     <= '0;
      im_acc     <= '0;
      addr_r     <= '0;
    end else begin
      if (start_ok) begin
        re_start_r <= re_start;
        step_r     <= step;
        x_cnt      <= '0;
        y_cnt      <= '0;
        re_acc     <= re_start;
        im_acc     <= im_start;
      end else if (d_state == D_PULSE && !last_pix) begin
        if (x_cnt == X_LAST) begin
          x_cnt  <= '0;
          re_acc <= re_start_r;
          y_cnt  <= y_cnt + 9'd1;
          im_acc <= im_acc - step_r;
        end else begin
          x_cnt  <= x_cnt + 10'd1;
          re_acc <= re_acc + step_r;
        end
      end
      if (d_state == D_SEL && avail_any) addr_r <= ADDR_W'(avail_idx);
    end
  end

  // ---------------- collect FSM ----------------
  // The engine just acknowledged keeps service_req high briefly; hide it.
  always_comb begin
    mask_vec = '0;
    if (mask_cnt != 2'd0) mask_vec[ack_idx] = 1'b1;
  end

  assign req_avail = service_req & ~mask_vec;

  // Round-robin search starting at rr_ptr (one past the last serviced engine).
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N_ENGINES; k++) begin
      int unsigned j;
      j = (32'(rr_ptr) + k) % N_ENGINES;
      if (!pick_any && req_avail[IDX_W'(j)]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(j);
      end
    end
  end

  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) c_state <= C_IDLE;
    else         c_state <= c_next;
  end

  always_comb begin
    c_next  = c_state;
    req_ack = '0;
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    case (c_state)
      C_IDLE: if (busy && pick_any) c_next = C_ACK;
      C_ACK: begin
        req_ack[ack_idx] = 1'b1;
        c_next           = C_HOLD;
      end
      C_HOLD: begin
        fb_we   = 1'b1;
        fb_addr = cap_addr;
        fb_data = cap_iter;
        c_next  = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) begin
      rr_ptr     <= '0;
      ack_idx    <= '0;
      mask_cnt   <= '0;
      cap_addr   <= '0;
      cap_iter   <= '0;
      res_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (c_state == C_IDLE && busy && pick_any) begin
        ack_idx <= pick_idx;
        rr_ptr  <= (32'(pick_idx) == N_ENGINES - 1) ? '0 : pick_idx + IDX_W'(1);
      end
      if (c_state == C_ACK) begin
        // Address comes from the returned word: results arrive out of order.
        cap_addr <= 19'(out_word[16:8]) * 19'(H_RES) + 19'(out_word[26:17]);
        cap_iter <= out_word[7:0];
        mask_cnt <= 2'd2;
      end else if (mask_cnt != 2'd0) begin
        mask_cnt <= mask_cnt - 2'd1;
      end
      if (start_ok) begin
        busy    <= 1'b1;
        res_cnt <= '0;
      end else if (c_state == C_HOLD) begin
        if (res_cnt == PIX_LAST) begin
          res_cnt    <= '0;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          res_cnt <= res_cnt + 19'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_engine_scheduler.sv
// Bench for engine_scheduler: engine-array model, raster reference queue,
// frame-buffer scoreboard with a separate monitor.
module tb_engine_scheduler;

  localparam int NE   = 2;
  localparam int AW   = 1;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int NPIX = HR * VR;

  logic          Engine_CLK = 1'b0;
  logic          eRST_n;
  logic          start;
  logic [31:0]   re_start, im_start, step;
  logic [NE-1:0] available, service_req;
  logic [26:0]   out_word;
  logic [AW-1:0] engine_addr;
  logic [82:0]   in_word;
  logic          latch_en;
  logic [NE-1:0] req_ack;
  logic          fb_we;
  logic [18:0]   fb_addr;
  logic [7:0]    fb_data;
  logic          busy, frame_done;

  always #5 Engine_CLK = ~Engine_CLK;

  engine_scheduler #(
    .N_ENGINES(NE),
    .ADDR_W   (AW),
    .H_RES    (HR),
    .V_RES    (VR)
  ) dut (
    .Engine_CLK (Engine_CLK),
    .eRST_n     (eRST_n),
    .start      (start),
    .re_start   (re_start),
    .im_start   (im_start),
    .step       (step),
    .available  (available),
    .service_req(service_req),
    .out_word   (out_word),
    .engine_addr(engine_addr),
    .in_word    (in_word),
    .latch_en   (latch_en),
    .req_ack    (req_ack),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [82:0]   exp_disp[$];
  logic [26:0]   exp_fb[$];
  int            ack_log[$];
  int            disp_count = 0;
  int            fb_count   = 0;
  logic [AW-1:0] last_addr;
  bit            done_seen;
  bit            written[NPIX];

  int            est[NE];
  int            ecnt[NE];
  logic [9:0]    ex[NE];
  logic [8:0]    ey[NE];
  logic [7:0]    eiter[NE];
  logic [NE-1:0] en_mask;
  bit            hold;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [31:0] re0, input logic [31:0] im0, input logic [31:0] st0);
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++) begin
        logic [31:0] r, m;
        r = re0 + 32'(x) * st0;
        m = im0 - 32'(y) * st0;
        exp_disp.push_back({10'(x), 9'(y), r, m});
      end
  endtask

  task automatic do_start(input logic [31:0] re0, input logic [31:0] im0, input logic [31:0] st0);
    @(negedge Engine_CLK);
    check("start_while_idle", busy, 1'b0);
    re_start = re0; im_start = im0; step = st0; start = 1'b1;
    push_frame(re0, im0, st0);
    done_seen = 0; fb_count = 0;
    for (int i = 0; i < NPIX; i++) written[i] = 0;
    @(negedge Engine_CLK);
    start = 1'b0;
    re_start = $urandom; im_start = $urandom; step = $urandom;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && !done_seen; i++) @(negedge Engine_CLK);
    check("frame_done_seen", done_seen, 1'b1);
  endtask

  task automatic wait_disp(input int n, input int max_cyc);
    for (int i = 0; i < max_cyc && disp_count < n; i++) @(negedge Engine_CLK);
    check("dispatch_seen", disp_count >= n, 1'b1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {engine_addr, in_word, latch_en, req_ack, fb_we, fb_addr, fb_data, busy, frame_done}, '0);
  endtask

  // Result bus: the acknowledged engine drives its word.
  always_comb begin
    out_word = '0;
    for (int i = 0; i < NE; i++)
      if (req_ack[i]) out_word = {ex[i], ey[i], eiter[i]};
  end

  // Engine array model, updated on the falling edge.
  initial begin
    available   = '0;
    service_req = '0;
    for (int i = 0; i < NE; i++) begin
      est[i] = 0; ecnt[i] = 0; ex[i] = '0; ey[i] = '0; eiter[i] = '0;
    end
    forever begin
      @(negedge Engine_CLK);
      if (!eRST_n) begin
        available = '0; service_req = '0;
        for (int i = 0; i < NE; i++) est[i] = 0;
        continue;
      end
      for (int i = 0; i < NE; i++) begin
        case (est[i])
          0: if (latch_en && engine_addr == AW'(i)) begin
               ex[i]        = in_word[82:73];
               ey[i]        = in_word[72:64];
               eiter[i]     = 8'($urandom);
               ecnt[i]      = $urandom_range(0, 10);
               est[i]       = 1;
               available[i] = 1'b0;
             end else begin
               available[i] = en_mask[i];
             end
          1: if (ecnt[i] > 0) ecnt[i]--;
             else if (!hold) begin service_req[i] = 1'b1; est[i] = 2; end
          2: if (req_ack[i]) begin
               exp_fb.push_back({19'(int'(ey[i]) * HR + int'(ex[i])), eiter[i]});
               est[i] = 3;
             end
          3: est[i] = 4;
          default: begin
            service_req[i] = 1'b0;
            available[i]   = en_mask[i];
            est[i]         = 0;
          end
        endcase
      end
    end
  end

  // Monitor: compares every DUT presentation against the queued expectations.
  initial begin
    logic prev_latch, prev_ack;
    prev_latch = 1'b0;
    prev_ack   = 1'b0;
    forever begin
      @(posedge Engine_CLK);
      #1;
      if (!eRST_n) begin prev_latch = 1'b0; prev_ack = 1'b0; continue; end
      if (latch_en) begin
        check("latch_gap", prev_latch, 1'b0);
        check("latch_target_available", available[engine_addr], 1'b1);
        check("disp_expected_pending", exp_disp.size() > 0, 1'b1);
        if (exp_disp.size() > 0) check("in_word", in_word, exp_disp.pop_front());
        disp_count++;
        last_addr = engine_addr;
      end
      prev_latch = latch_en;
      if (req_ack != '0) begin
        check("ack_onehot", $onehot(req_ack), 1'b1);
        check("ack_has_req", req_ack & ~service_req, '0);
        check("ack_one_cycle", prev_ack, 1'b0);
        for (int i = 0; i < NE; i++) if (req_ack[i]) ack_log.push_back(i);
      end
      prev_ack = (req_ack != '0);
      if (fb_we) begin
        check("fb_expected_pending", exp_fb.size() > 0, 1'b1);
        if (exp_fb.size() > 0) check("fb_addr_data", {fb_addr, fb_data}, exp_fb.pop_front());
        check("fb_addr_range", fb_addr < 19'(NPIX), 1'b1);
        if (fb_addr < 19'(NPIX)) begin
          check("fb_addr_once", written[fb_addr], 1'b0);
          written[fb_addr] = 1;
        end
        fb_count++;
      end
      if (frame_done) begin
        check("frame_done_count", fb_count, NPIX);
        check("frame_done_busy", busy, 1'b0);
        check("frame_done_disp_left", exp_disp.size(), 0);
        done_seen = 1;
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    eRST_n = 1'b0; start = 1'b0;
    re_start = '0; im_start = '0; step = '0;
    en_mask = '0; hold = 0;
    repeat (3) @(negedge Engine_CLK);
    check_all_zero("reset_outputs");
    eRST_n = 1'b1;

    // Raster sequence and simultaneous requests serviced 0 then 1.
    en_mask = 2'b11; hold = 1;
    repeat (2) @(negedge Engine_CLK);
    do_start(32'hFE000000, 32'h01000000, 32'h01000000);
    repeat (40) @(negedge Engine_CLK);
    hold = 0;
    wait_done(400);
    check("ack_log_len", ack_log.size() >= 2, 1'b1);
    if (ack_log.size() >= 2) begin
      check("first_ack", ack_log[0], 0);
      check("second_ack", ack_log[1], 1);
    end

    // No engine available: dispatch must stall, then target engine 1.
    en_mask = '0;
    repeat (2) @(negedge Engine_CLK);
    d0 = disp_count;
    do_start($urandom, $urandom, $urandom);
    repeat (20) @(negedge Engine_CLK);
    check("no_dispatch_while_unavailable", disp_count, d0);
    en_mask = 2'b10;
    wait_disp(d0 + 1, 50);
    check("first_addr_engine1", last_addr, 1'b1);
    en_mask = 2'b11;
    wait_done(400);

    // start during a frame is ignored.
    d0 = disp_count;
    do_start($urandom, $urandom, $urandom);
    wait_disp(d0 + 3, 200);
    @(negedge Engine_CLK);
    re_start = $urandom; im_start = $urandom; step = $urandom; start = 1'b1;
    @(negedge Engine_CLK);
    start = 1'b0;
    check("busy_after_ignored_start", busy, 1'b1);
    wait_done(400);

    // Random views with random engine latency (out-of-order returns).
    for (int f = 0; f < 4; f++) begin
      do_start($urandom, $urandom, $urandom);
      wait_done(400);
    end

    // Asynchronous reset mid-frame, then a clean restart from x=y=0.
    d0 = disp_count;
    do_start($urandom, $urandom, $urandom);
    wait_disp(d0 + 4, 200);
    @(posedge Engine_CLK);
    #3;
    eRST_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    exp_disp.delete(); exp_fb.delete(); ack_log.delete();
    repeat (2) @(negedge Engine_CLK);
    eRST_n = 1'b1;
    do_start(32'hFE000000, 32'h00800000, 32'h01000000);
    wait_done(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
